// File: rtl/recorder_mem_arbiter_pkg.sv
// rtl/recorder_mem_arbiter_pkg.sv - shared types and constants for the recorder memory arbiter
package recorder_mem_arbiter_pkg;

  localparam int NR_OF_REQUESTERS_C = 2;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/recorder_mem_arbiter_if.sv
// rtl/recorder_mem_arbiter_if.sv - single-beat AXI port bundle (AW/W/AR/R, no B channel)
interface recorder_mem_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    output arid, araddr, arlen, arvalid, input arready,
    input rid, rdata, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    input arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rlast, rvalid, input rready
  );
endinterface

// File: rtl/recorder_mem_arbiter_rr_arbiter_2.sv
// rtl/recorder_mem_arbiter_rr_arbiter_2.sv - two-input round-robin picker with registered last winner
module rr_arbiter_2
  import recorder_mem_arbiter_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NR_OF_REQUESTERS_C-1:0] req,
  input  logic                          update,
  input  logic                          upd_idx,
  output logic                          gnt
);

  logic last;

  // On a tie the side that did not win last time goes next.
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= upd_idx;
    end
  end

endmodule

// File: rtl/recorder_mem_arbiter.sv
// rtl/recorder_mem_arbiter.sv - shares one AXI memory port between two single-beat recorders
module recorder_mem_arbiter
  import recorder_mem_arbiter_pkg::*;
#(
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int AXI_ADDR_WIDTH_P = 32,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_STRB_WIDTH_P = AXI_DATA_WIDTH_P / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  recorder_mem_arbiter_if.slave         rec0,
  recorder_mem_arbiter_if.slave         rec1,
  recorder_mem_arbiter_if.master        mem,
  output logic                          sr_wr_owner,
  output logic                          sr_rd_owner
);

  wr_state_t wr_state;
  rd_state_t rd_state;
  logic      wr_gnt, rd_gnt;
  logic      wr_pick, rd_pick;
  logic      wr_done, rd_done;

  logic [AXI_ID_WIDTH_P-1:0]   aw_id_sel, ar_id_sel;
  logic [AXI_ADDR_WIDTH_P-1:0] aw_addr_sel, ar_addr_sel;
  logic [AXI_DATA_WIDTH_P-1:0] w_data_sel;
  logic [AXI_STRB_WIDTH_P-1:0] w_strb_sel;
  logic                        w_valid_sel, w_last_sel, r_ready_sel;

  assign aw_id_sel   = wr_gnt ? rec1.awid   : rec0.awid;
  assign aw_addr_sel = wr_gnt ? rec1.awaddr : rec0.awaddr;
  assign w_data_sel  = wr_gnt ? rec1.wdata  : rec0.wdata;
  assign w_strb_sel  = wr_gnt ? rec1.wstrb  : rec0.wstrb;
  assign w_valid_sel = wr_gnt ? rec1.wvalid : rec0.wvalid;
  assign w_last_sel  = wr_gnt ? rec1.wlast  : rec0.wlast;
  assign ar_id_sel   = rd_gnt ? rec1.arid   : rec0.arid;
  assign ar_addr_sel = rd_gnt ? rec1.araddr : rec0.araddr;
  assign r_ready_sel = rd_gnt ? rec1.rready : rec0.rready;

  assign wr_done = (wr_state == WR_DATA) && w_valid_sel && mem.wready && w_last_sel;
  assign rd_done = (rd_state == RD_DATA) && mem.rvalid && r_ready_sel && mem.rlast;

  rr_arbiter_2 u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({rec1.awvalid, rec0.awvalid}),
    .update  (wr_done),
    .upd_idx (wr_gnt),
    .gnt     (wr_pick)
  );

  rr_arbiter_2 u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({rec1.arvalid, rec0.arvalid}),
    .update  (rd_done),
    .upd_idx (rd_gnt),
    .gnt     (rd_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      wr_gnt   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (rec0.awvalid || rec1.awvalid) begin
          wr_gnt   <= wr_pick;
          wr_state <= WR_ADDR;
        end
        WR_ADDR: if (mem.awvalid && mem.awready) wr_state <= WR_DATA;
        WR_DATA: if (wr_done) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_gnt   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: if (rec0.arvalid || rec1.arvalid) begin
          rd_gnt   <= rd_pick;
          rd_state <= RD_ADDR;
        end
        RD_ADDR: if (mem.arvalid && mem.arready) rd_state <= RD_DATA;
        RD_DATA: if (rd_done) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Payloads are forced to zero outside their phase so idle/reset outputs are clean.
  always_comb begin
    mem.awid     = '0;
    mem.awaddr   = '0;
    mem.awlen    = '0;
    mem.awvalid  = 1'b0;
    mem.wdata    = '0;
    mem.wstrb    = '0;
    mem.wlast    = 1'b0;
    mem.wvalid   = 1'b0;
    rec0.awready = 1'b0;
    rec1.awready = 1'b0;
    rec0.wready  = 1'b0;
    rec1.wready  = 1'b0;
    if (wr_state == WR_ADDR) begin
      mem.awid    = aw_id_sel;
      mem.awaddr  = aw_addr_sel;
      mem.awlen   = wr_gnt ? rec1.awlen : rec0.awlen;
      mem.awvalid = wr_gnt ? rec1.awvalid : rec0.awvalid;
      if (wr_gnt) rec1.awready = mem.awready;
      else        rec0.awready = mem.awready;
    end
    if (wr_state == WR_DATA) begin
      mem.wdata  = w_data_sel;
      mem.wstrb  = w_strb_sel;
      mem.wlast  = w_last_sel;
      mem.wvalid = w_valid_sel;
      if (wr_gnt) rec1.wready = mem.wready;
      else        rec0.wready = mem.wready;
    end
  end

  // R beats follow the grant, never rid.
  always_comb begin
    mem.arid     = '0;
    mem.araddr   = '0;
    mem.arlen    = '0;
    mem.arvalid  = 1'b0;
    mem.rready   = 1'b0;
    rec0.arready = 1'b0;
    rec1.arready = 1'b0;
    rec0.rid     = '0;
    rec0.rdata   = '0;
    rec0.rlast   = 1'b0;
    rec0.rvalid  = 1'b0;
    rec1.rid     = '0;
    rec1.rdata   = '0;
    rec1.rlast   = 1'b0;
    rec1.rvalid  = 1'b0;
    if (rd_state == RD_ADDR) begin
      mem.arid    = ar_id_sel;
      mem.araddr  = ar_addr_sel;
      mem.arlen   = rd_gnt ? rec1.arlen : rec0.arlen;
      mem.arvalid = rd_gnt ? rec1.arvalid : rec0.arvalid;
      if (rd_gnt) rec1.arready = mem.arready;
      else        rec0.arready = mem.arready;
    end
    if (rd_state == RD_DATA) begin
      mem.rready = r_ready_sel;
      if (rd_gnt) begin
        rec1.rid    = mem.rid;
        rec1.rdata  = mem.rdata;
        rec1.rlast  = mem.rlast;
        rec1.rvalid = mem.rvalid;
      end else begin
        rec0.rid    = mem.rid;
        rec0.rdata  = mem.rdata;
        rec0.rlast  = mem.rlast;
        rec0.rvalid = mem.rvalid;
      end
    end
  end

  assign sr_wr_owner = wr_gnt;
  assign sr_rd_owner = rd_gnt;

endmodule
